// File: rtl/ita_output_stage.sv
// ----------------------------------------------------------------------------
// ita_output_stage
//
// Output stage behind the ITA activation unit. The stage buffers full result
// rows of N*WI bits in a circular FIFO. It splits each row into BEATS output
// beats of OUT_ELEMS elements, and it forwards the end-of-tile marker on the
// final beat of a tagged row. It also reports occupancy and an almost-full
// credit so the controller can throttle before in-flight results overflow.
//
// Optional build macro: ITA_OUT_MONITOR_EN
//   defined   -> usage_max_o (high-water mark) and overflow_o (sticky) are live
//   undefined -> both outputs are tied to 0 and their registers are removed
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-high reset
//   flush_i        synchronous clear of all contents (highest priority)
//   push_valid_i   input row valid
//   push_ready_o   input row accepted (= !full && !flush_i)
//   push_data_i    input row, element 0 in the LSBs
//   push_last_i    input row closes a tile
//   almost_full_o  usage_o >= ALMOST_FULL_TH
//   valid_o        output beat valid
//   ready_i        sink ready
//   oup_o          output beat data, '0 while valid_o is low
//   last_o         final beat of a row pushed with push_last_i
//   usage_o        FIFO entries held, excluding the beat register
//   usage_max_o    high-water mark of usage_o
//   overflow_o     sticky: a push was attempted while full
// ----------------------------------------------------------------------------
module ita_output_stage #(
  parameter int N              = 16,
  parameter int WI             = 8,
  parameter int FIFO_DEPTH     = 8,
  parameter int OUT_ELEMS      = 16,
  parameter int ALMOST_FULL_TH = FIFO_DEPTH - 2
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               flush_i,
  input  logic                               push_valid_i,
  output logic                               push_ready_o,
  input  logic [N*WI-1:0]                    push_data_i,
  input  logic                               push_last_i,
  output logic                               almost_full_o,
  output logic                               valid_o,
  input  logic                               ready_i,
  output logic [OUT_ELEMS*WI-1:0]            oup_o,
  output logic                               last_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    usage_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    usage_max_o,
  output logic                               overflow_o
);

  localparam int ROW_W = N * WI;
  localparam int OUT_W = OUT_ELEMS * WI;
  localparam int BEATS = N / OUT_ELEMS;
  localparam int UW    = $clog2(FIFO_DEPTH + 1);
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [UW-1:0] FULL_CNT  = UW'(FIFO_DEPTH);
  localparam logic [UW-1:0] AF_TH     = UW'(ALMOST_FULL_TH);
  localparam logic [PW-1:0] LAST_PTR  = PW'(FIFO_DEPTH - 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  logic [ROW_W:0]  mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [UW-1:0]   count;
  logic [UW-1:0]   count_next;
  logic            full;
  logic            empty;
  logic            do_push;
  logic            do_pop;

  state_t          state;
  logic [BW-1:0]   beat;
  logic [ROW_W-1:0] row_data;
  logic            row_last;
  logic            last_beat;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign last_beat = (beat == LAST_BEAT);

  // Ready never looks ahead to a same-cycle pop, so it depends on the
  // registered full flag and flush only.
  assign push_ready_o = !full && !flush_i;
  assign do_push      = push_valid_i && push_ready_o;

  // The head row leaves the FIFO either to fill an empty beat register or
  // back-to-back when the final beat of the current row is accepted.
  assign do_pop = !flush_i && !empty &&
                  ((state == IDLE) || (ready_i && last_beat));

  // Pointers wrap explicitly so that non-power-of-two depths work.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Row storage carries no reset: contents are only visible through count.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr] <= {push_last_i, push_data_i};
    end
  end

  // Next occupancy, shared by the counter and the high-water mark.
  always_comb begin
    count_next = count;
    if (flush_i) begin
      count_next = '0;
    end else if (do_push && !do_pop) begin
      count_next = count + UW'(1);
    end else if (!do_push && do_pop) begin
      count_next = count - UW'(1);
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count_next;
      if (flush_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push) wr_ptr <= next_ptr(wr_ptr);
        if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      end
    end
  end

  // Serializer: holds one row and walks the beat counter on each accepted
  // beat, refilling from the FIFO in the same cycle as the final beat.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      beat     <= '0;
      row_data <= '0;
      row_last <= 1'b0;
    end else if (flush_i) begin
      state <= IDLE;
      beat  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            {row_last, row_data} <= mem[rd_ptr];
            beat  <= '0;
            state <= STREAM;
          end
        end
        STREAM: begin
          if (ready_i) begin
            if (!last_beat) begin
              beat <= beat + BW'(1);
            end else if (!empty) begin
              {row_last, row_data} <= mem[rd_ptr];
              beat <= '0;
            end else begin
              beat  <= '0;
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          beat  <= '0;
        end
      endcase
    end
  end

  assign valid_o       = (state == STREAM);
  assign oup_o         = valid_o ? row_data[int'(beat)*OUT_W +: OUT_W] : '0;
  assign last_o        = valid_o && last_beat && row_last;
  assign usage_o       = count;
  assign almost_full_o = (count >= AF_TH);

`ifdef ITA_OUT_MONITOR_EN
  logic [UW-1:0] usage_max;
  logic          overflow;

  // High-water mark tracks the next occupancy so it never lags usage_o.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      usage_max <= '0;
      overflow  <= 1'b0;
    end else if (flush_i) begin
      usage_max <= '0;
      overflow  <= 1'b0;
    end else begin
      if (count_next > usage_max) usage_max <= count_next;
      if (push_valid_i && full)   overflow  <= 1'b1;
    end
  end

  assign usage_max_o = usage_max;
  assign overflow_o  = overflow;
`else
  assign usage_max_o = '0;
  assign overflow_o  = 1'b0;
`endif

endmodule

// File: tb/tb_ita_output_stage.sv
// ----------------------------------------------------------------------------
// tb_ita_output_stage
//
// Scoreboard bench for ita_output_stage with N=16, WI=8, OUT_ELEMS=4,
// FIFO_DEPTH=4, ALMOST_FULL_TH=2. Accepted rows are split into expected beats
// and queued; a negedge monitor pops and compares every accepted output beat.
// Expectations for usage_max_o/overflow_o follow ITA_OUT_MONITOR_EN.
// ----------------------------------------------------------------------------
module tb_ita_output_stage;

  localparam int N     = 16;
  localparam int WI    = 8;
  localparam int DEPTH = 4;
  localparam int OE    = 4;
  localparam int TH    = 2;
  localparam int UW    = $clog2(DEPTH + 1);

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               flush_i;
  logic               push_valid_i;
  logic               push_ready_o;
  logic [N*WI-1:0]    push_data_i;
  logic               push_last_i;
  logic               almost_full_o;
  logic               valid_o;
  logic               ready_i;
  logic [OE*WI-1:0]   oup_o;
  logic               last_o;
  logic [UW-1:0]      usage_o;
  logic [UW-1:0]      usage_max_o;
  logic               overflow_o;

  ita_output_stage #(
    .N(N), .WI(WI), .FIFO_DEPTH(DEPTH), .OUT_ELEMS(OE), .ALMOST_FULL_TH(TH)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .push_valid_i(push_valid_i), .push_ready_o(push_ready_o),
    .push_data_i(push_data_i), .push_last_i(push_last_i),
    .almost_full_o(almost_full_o), .valid_o(valid_o), .ready_i(ready_i),
    .oup_o(oup_o), .last_o(last_o), .usage_o(usage_o),
    .usage_max_o(usage_max_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  int          beat_log[$];
  logic [31:0] data_log[$];
  logic        last_log[$];
  int          tests  = 0;
  int          errors = 0;
  int          cyc    = 0;
  int          obs_max = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Shared comparison: counts every check and reports each failure.
  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    tests++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d",
               name, actual, expected, cyc);
    end
  endtask

  // Expected value of a monitor-only output in the current build.
  function automatic logic [3:0] monExp(input logic [3:0] v);
`ifdef ITA_OUT_MONITOR_EN
    return v;
`else
    return 4'd0;
`endif
  endfunction

  // Reference model: a row leaves as four 32-bit slices, low slice first,
  // with the tile marker only on the final slice.
  function automatic void expectRow(input logic [127:0] row, input logic lst);
    beat_t b;
    for (int k = 0; k < N / OE; k++) begin
      b.data = row[k*32 +: 32];
      b.last = lst && (k == N / OE - 1);
      exp_q.push_back(b);
    end
  endfunction

  // Drive one cycle of inputs just after the rising edge; a row accepted by
  // the handshake is registered with the scoreboard.
  task automatic applyStimulus(input logic pv, input logic [127:0] data,
                               input logic pl, input logic rdy,
                               input logic fl, input logic gate);
    logic pv_eff;
    @(posedge clk_i);
    #1;
    pv_eff       = gate ? (pv && push_ready_o) : pv;
    push_valid_i = pv_eff;
    push_data_i  = data;
    push_last_i  = pl;
    flush_i      = fl;
    ready_i      = fl ? 1'b0 : rdy;
    #1;
    if (pv_eff && push_ready_o) expectRow(data, pl);
    if (fl) exp_q.delete();
  endtask

  task automatic idleCycle(input logic rdy);
    applyStimulus(1'b0, '0, 1'b0, rdy, 1'b0, 1'b0);
  endtask

  task automatic waitDrain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) idleCycle(1'b1);
    idleCycle(1'b1);
    checkOutput("drain_done", 128'(exp_q.size()), 128'd0);
  endtask

  function automatic logic [127:0] randRow();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Monitor: on every accepted beat compare against the scoreboard head.
  always @(negedge clk_i) begin
    beat_t e;
    if (!rst_i) begin
      if (int'(usage_o) > obs_max) obs_max = int'(usage_o);
      if (valid_o && ready_i) begin
        beat_log.push_back(cyc);
        data_log.push_back(oup_o);
        last_log.push_back(last_o);
        if (exp_q.size() == 0) begin
          checkOutput("beat_expected", 128'(oup_o), 128'hDEAD_0000_0000_0000_0000_0000_0000_0000);
        end else begin
          e = exp_q.pop_front();
          checkOutput("beat_data", 128'(oup_o), 128'(e.data));
          checkOutput("beat_last", 128'(last_o), 128'(e.last));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [127:0] row;
    logic [127:0] row1;
    logic [31:0]  held;
    int           push_cyc;
    int           exp_use[5] = '{0, 1, 1, 2, 3};

    rst_i = 1'b1; flush_i = 1'b0; push_valid_i = 1'b0; push_data_i = '0;
    push_last_i = 1'b0; ready_i = 1'b0;

    // Reset values
    #12;
    checkOutput("rst_push_ready", 128'(push_ready_o), 128'd1);
    checkOutput("rst_almost_full", 128'(almost_full_o), 128'd0);
    checkOutput("rst_valid", 128'(valid_o), 128'd0);
    checkOutput("rst_oup", 128'(oup_o), 128'd0);
    checkOutput("rst_last", 128'(last_o), 128'd0);
    checkOutput("rst_usage", 128'(usage_o), 128'd0);
    checkOutput("rst_usage_max", 128'(usage_max_o), 128'd0);
    checkOutput("rst_overflow", 128'(overflow_o), 128'd0);
    rst_i = 1'b0;

    // Serialization of one tagged row
    row = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    beat_log.delete(); data_log.delete(); last_log.delete();
    applyStimulus(1'b1, row, 1'b1, 1'b1, 1'b0, 1'b0);
    push_cyc = cyc;
    waitDrain(20);
    checkOutput("ser_beats", 128'(data_log.size()), 128'd4);
    if (data_log.size() == 4) begin
      checkOutput("ser_beat0", 128'(data_log[0]), 128'h03020100);
      checkOutput("ser_beat1", 128'(data_log[1]), 128'h07060504);
      checkOutput("ser_beat2", 128'(data_log[2]), 128'h0B0A0908);
      checkOutput("ser_beat3", 128'(data_log[3]), 128'h0F0E0D0C);
      checkOutput("ser_last_early", 128'({last_log[0], last_log[1], last_log[2]}), 128'd0);
      checkOutput("ser_last_final", 128'(last_log[3]), 128'd1);
      checkOutput("ser_latency", 128'(beat_log[0] - push_cyc), 128'd2);
      checkOutput("ser_no_gap", 128'(beat_log[3] - beat_log[0]), 128'd3);
    end

    // Backpressure: five rows with the sink stalled
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, randRow(), 1'(i == 4), 1'b0, 1'b0, 1'b0);
      checkOutput("bp_usage_step", 128'(usage_o), 128'(exp_use[i]));
      checkOutput("bp_af_rule", 128'(almost_full_o), 128'(usage_o >= UW'(TH)));
    end
    idleCycle(1'b0);
    checkOutput("bp_usage_full", 128'(usage_o), 128'd4);
    checkOutput("bp_push_ready", 128'(push_ready_o), 128'd0);
    checkOutput("bp_almost_full", 128'(almost_full_o), 128'd1);
    checkOutput("bp_valid", 128'(valid_o), 128'd1);
    checkOutput("bp_usage_max", 128'(usage_max_o), 128'(monExp(4'd4)));
    checkOutput("bp_queued", 128'(exp_q.size()), 128'd20);
    held = oup_o;
    if (exp_q.size() != 0) checkOutput("bp_head", 128'(held), 128'(exp_q[0].data));

    // Overflow: a push while full is dropped and flagged
    applyStimulus(1'b1, {4{32'hBADBAD00}}, 1'b1, 1'b0, 1'b0, 1'b0);
    idleCycle(1'b0);
    checkOutput("ovf_flag", 128'(overflow_o), 128'(monExp(4'd1)));
    checkOutput("ovf_usage", 128'(usage_o), 128'd4);
    checkOutput("bp_oup_stable", 128'(oup_o), 128'(held));
    idleCycle(1'b0);
    checkOutput("ovf_sticky", 128'(overflow_o), 128'(monExp(4'd1)));

    // Drain 20 beats without gaps
    beat_log.delete(); data_log.delete(); last_log.delete();
    waitDrain(60);
    checkOutput("drain_count", 128'(beat_log.size()), 128'd20);
    if (beat_log.size() == 20)
      checkOutput("drain_no_gap", 128'(beat_log[19] - beat_log[0]), 128'd19);
    idleCycle(1'b1);
    checkOutput("drain_valid", 128'(valid_o), 128'd0);
    checkOutput("drain_oup", 128'(oup_o), 128'd0);
    checkOutput("drain_usage", 128'(usage_o), 128'd0);

    // Flush mid-stream during beat 2 with three rows queued
    row1 = randRow();
    applyStimulus(1'b1, row1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, randRow(), 1'b1, 1'b0, 1'b0, 1'b0);
    idleCycle(1'b1);
    idleCycle(1'b1);
    applyStimulus(1'b1, {4{32'hF1F1F1F1}}, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("fl_pre_usage", 128'(usage_o), 128'd3);
    checkOutput("fl_pre_beat2", 128'(oup_o), 128'(row1[95:64]));
    checkOutput("fl_push_ready", 128'(push_ready_o), 128'd0);
    idleCycle(1'b0);
    checkOutput("fl_valid", 128'(valid_o), 128'd0);
    checkOutput("fl_oup", 128'(oup_o), 128'd0);
    checkOutput("fl_usage", 128'(usage_o), 128'd0);
    checkOutput("fl_usage_max", 128'(usage_max_o), 128'd0);
    checkOutput("fl_overflow", 128'(overflow_o), 128'd0);
    for (int i = 0; i < 3; i++) idleCycle(1'b1);
    checkOutput("fl_not_stored", 128'(valid_o), 128'd0);
    checkOutput("fl_usage_after", 128'(usage_o), 128'd0);

    // Asynchronous reset while streaming
    applyStimulus(1'b1, randRow(), 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, randRow(), 1'b1, 1'b1, 1'b0, 1'b0);
    idleCycle(1'b1);
    @(posedge clk_i);
    #3;
    rst_i = 1'b1;
    exp_q.delete();
    #1;
    checkOutput("arst_valid", 128'(valid_o), 128'd0);
    checkOutput("arst_oup", 128'(oup_o), 128'd0);
    checkOutput("arst_last", 128'(last_o), 128'd0);
    checkOutput("arst_usage", 128'(usage_o), 128'd0);
    checkOutput("arst_usage_max", 128'(usage_max_o), 128'd0);
    checkOutput("arst_push_ready", 128'(push_ready_o), 128'd1);
    checkOutput("arst_almost_full", 128'(almost_full_o), 128'd0);
    @(negedge clk_i);
    #2;
    rst_i = 1'b0;
    row = randRow();
    beat_log.delete(); data_log.delete(); last_log.delete();
    applyStimulus(1'b1, row, 1'b1, 1'b1, 1'b0, 1'b0);
    waitDrain(20);
    checkOutput("arst_new_beats", 128'(data_log.size()), 128'd4);
    if (data_log.size() != 0)
      checkOutput("arst_new_beat0", 128'(data_log[0]), 128'(row[31:0]));

    // Random push/pop, sink ready about 30% of cycles
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    idleCycle(1'b0);
    obs_max = 0;
    for (int i = 0; i < 2000; i++) begin
      applyStimulus(1'($urandom_range(0, 99) < 60), randRow(), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 9) < 3), 1'b0, 1'b1);
      checkOutput("rnd_af_rule", 128'(almost_full_o), 128'(usage_o >= UW'(TH)));
      checkOutput("rnd_ready_rule", 128'(push_ready_o), 128'(usage_o != UW'(DEPTH)));
    end
    waitDrain(200);
    checkOutput("rnd_overflow", 128'(overflow_o), 128'd0);
    checkOutput("rnd_usage_max", 128'(usage_max_o), 128'(monExp(4'(obs_max))));

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
